// File: rtl/hazard_controller.sv
// Hazard scheduler for the 5-stage RV32I pipeline: EX forwarding selects, load-use bubbles,
// branch flushes and data-memory wait stalls, with saturating perf counters and a sticky timeout flag.
module hazard_controller #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             memReadE,
    input  logic             pcsrcE,
    input  logic             regwriteM,
    input  logic [4:0]       rdM,
    input  logic             regwriteW,
    input  logic [4:0]       rdW,
    input  logic             mem_busyM,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout,
    output logic             fsm_state
);

    // Handshake: none; every input is sampled combinationally each cycle and the
    // stall/flush outputs apply to the pipeline registers on the same rising edge.

    localparam int WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]   WAIT_MAX = WCW'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t         state, state_next;
    logic [WCW-1:0] wait_cnt, wait_next;
    logic           timeout_set;
    logic           branch_flush;
    logic           lu;

    assign fsm_state = state;
    assign lu = memReadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (rst_n) begin
            if (regwriteM && rdM != 5'd0 && rdM == rs1E)      forwardAE = 2'b10;
            else if (regwriteW && rdW != 5'd0 && rdW == rs1E) forwardAE = 2'b01;
            if (regwriteM && rdM != 5'd0 && rdM == rs2E)      forwardBE = 2'b10;
            else if (regwriteW && rdW != 5'd0 && rdW == rs2E) forwardBE = 2'b01;
        end
    end

    always_comb begin
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushW       = 1'b0;
        state_next   = state;
        wait_next    = wait_cnt;
        timeout_set  = 1'b0;
        branch_flush = 1'b0;
        if (!rst_n) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushW = 1'b1;
        end else if (mem_busyM) begin
            // Freeze F..M and bubble W; pcsrcE/lu stay pending in the frozen stages.
            stallF     = 1'b1;
            stallD     = 1'b1;
            stallE     = 1'b1;
            stallM     = 1'b1;
            flushW     = 1'b1;
            state_next = MEM_WAIT;
            case (state)
                RUN: wait_next = WCW'(1);
                MEM_WAIT: begin
                    if (wait_cnt < WAIT_MAX) wait_next = wait_cnt + WCW'(1);
                    if (TIMEOUT != 0 && wait_cnt == WAIT_MAX) timeout_set = 1'b1;
                end
                default: wait_next = '0;
            endcase
        end else begin
            state_next = RUN;
            wait_next  = '0;
            if (pcsrcE) begin
                flushD       = 1'b1;
                flushE       = 1'b1;
                branch_flush = 1'b1;
            end else if (lu) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (timeout_set) mem_timeout <= 1'b1;
            if (stallF && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + CNT_W'(1);
            if (branch_flush && flush_events != CNT_MAX) flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, branch flush, memory wait,
// timeout flag, reset during a wait and counter saturation.
module tb_hazard_controller;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;

    logic             CLK = 1'b0;
    logic             rst_n;
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             memReadE, pcsrcE, regwriteM, regwriteW, mem_busyM;
    logic [1:0]       forwardAE, forwardBE;
    logic             stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic             mem_timeout, fsm_state;
    logic [6:0]       ctl;

    int checks = 0;
    int errors = 0;

    // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    localparam logic [6:0] CTL_IDLE   = 7'b0000_000;
    localparam logic [6:0] CTL_RESET  = 7'b0000_111;
    localparam logic [6:0] CTL_LU     = 7'b1100_010;
    localparam logic [6:0] CTL_BRANCH = 7'b0000_110;
    localparam logic [6:0] CTL_MEM    = 7'b1111_001;

    assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW};

    always #5 CLK = ~CLK;

    hazard_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .rst_n(rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .memReadE(memReadE), .pcsrcE(pcsrcE), .regwriteM(regwriteM), .rdM(rdM),
        .regwriteW(regwriteW), .rdW(rdW), .mem_busyM(mem_busyM), .forwardAE(forwardAE),
        .forwardBE(forwardBE), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .stall_cycles(stall_cycles), .flush_events(flush_events),
        .mem_timeout(mem_timeout), .fsm_state(fsm_state)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        memReadE = 0; pcsrcE = 0; regwriteM = 0; regwriteW = 0; mem_busyM = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        regwriteM = 1; rdM = 5; rs1E = 5; mem_busyM = 1;
        #1;
        checks++;
        if (ctl !== CTL_RESET) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RESET); end
        checks++;
        if (forwardAE !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b expected 00", forwardAE); end
        step();
        checks++;
        if ({fsm_state, mem_timeout, stall_cycles, flush_events} !== '0)
            begin errors++; $display("FAIL reset_state: state=%b to=%b sc=%0d fe=%0d expected all 0",
                                     fsm_state, mem_timeout, stall_cycles, flush_events); end
        clear_inputs();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_forwarding();
        do_reset();
        rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1; rs1E = 5; #1;
        checks++;
        if (forwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_wins: got %b expected 10", forwardAE); end
        regwriteM = 0; #1;
        checks++;
        if (forwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w: got %b expected 01", forwardAE); end
        regwriteM = 1; rs1E = 0; rdM = 0; #1;
        checks++;
        if (forwardAE !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b expected 00", forwardAE); end
        rs2E = 9; rdW = 9; rdM = 3; #1;
        checks++;
        if (forwardBE !== 2'b01) begin errors++; $display("FAIL fwd_b_w: got %b expected 01", forwardBE); end
        rdM = 9; #1;
        checks++;
        if (forwardBE !== 2'b10) begin errors++; $display("FAIL fwd_b_m: got %b expected 10", forwardBE); end
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL fwd_ctl: got %b expected %b", ctl, CTL_IDLE); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        memReadE = 1; rdE = 7; rs2D = 7; #1;
        checks++;
        if (ctl !== CTL_LU) begin errors++; $display("FAIL lu_ctl: got %b expected %b", ctl, CTL_LU); end
        step();
        memReadE = 0; rdE = 0; #1;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL lu_release: got %b expected %b", ctl, CTL_IDLE); end
        checks++;
        if (stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", stall_cycles); end
        memReadE = 1; rdE = 0; rs1D = 0; #1;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL lu_x0: got %b expected %b", ctl, CTL_IDLE); end
        clear_inputs();
    endtask

    task automatic test_branch_kills_lu();
        do_reset();
        pcsrcE = 1; memReadE = 1; rdE = 7; rs1D = 7; #1;
        checks++;
        if (ctl !== CTL_BRANCH) begin errors++; $display("FAIL br_ctl: got %b expected %b", ctl, CTL_BRANCH); end
        step();
        clear_inputs();
        #1;
        checks++;
        if (flush_events !== 4'd1 || stall_cycles !== 4'd0)
            begin errors++; $display("FAIL br_counts: fe=%0d sc=%0d expected fe=1 sc=0", flush_events, stall_cycles); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        pcsrcE = 1; mem_busyM = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== CTL_MEM) begin errors++; $display("FAIL mw_ctl%0d: got %b expected %b", i, ctl, CTL_MEM); end
            step();
            checks++;
            if (fsm_state !== 1'b1) begin errors++; $display("FAIL mw_state%0d: got %b expected 1", i, fsm_state); end
        end
        mem_busyM = 0; #1;
        checks++;
        if (ctl !== CTL_BRANCH) begin errors++; $display("FAIL mw_deferred_br: got %b expected %b", ctl, CTL_BRANCH); end
        step();
        clear_inputs();
        #1;
        checks++;
        if (stall_cycles !== 4'd3 || flush_events !== 4'd1 || fsm_state !== 1'b0)
            begin errors++; $display("FAIL mw_counts: sc=%0d fe=%0d st=%b expected sc=3 fe=1 st=0",
                                     stall_cycles, flush_events, fsm_state); end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_busyM = 1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (mem_timeout !== (k >= 5)) begin errors++; $display("FAIL to_edge%0d: got %b expected %b", k, mem_timeout, (k >= 5)); end
        end
        mem_busyM = 0;
        step();
        step();
        checks++;
        if (mem_timeout !== 1'b1 || ctl !== CTL_IDLE)
            begin errors++; $display("FAIL to_sticky: to=%b ctl=%b expected to=1 ctl=%b", mem_timeout, ctl, CTL_IDLE); end
        checks++;
        if (stall_cycles !== 4'd6) begin errors++; $display("FAIL to_count: got %0d expected 6", stall_cycles); end
    endtask

    task automatic test_reset_mid_wait();
        mem_busyM = 1;
        step();
        step();
        rst_n = 1'b0; #1;
        checks++;
        if (ctl !== CTL_RESET) begin errors++; $display("FAIL rmw_ctl: got %b expected %b", ctl, CTL_RESET); end
        step();
        checks++;
        if ({fsm_state, mem_timeout, stall_cycles, flush_events} !== '0)
            begin errors++; $display("FAIL rmw_state: state=%b to=%b sc=%0d fe=%0d expected all 0",
                                     fsm_state, mem_timeout, stall_cycles, flush_events); end
        rst_n = 1'b1; mem_busyM = 0; #1;
        checks++;
        if (ctl !== CTL_IDLE) begin errors++; $display("FAIL rmw_run: got %b expected %b", ctl, CTL_IDLE); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        pcsrcE = 1; #1;
        checks++;
        if (ctl !== CTL_BRANCH) begin errors++; $display("FAIL b2b_br: got %b expected %b", ctl, CTL_BRANCH); end
        step();
        pcsrcE = 0; memReadE = 1; rdE = 12; rs1D = 12; #1;
        checks++;
        if (ctl !== CTL_LU) begin errors++; $display("FAIL b2b_lu: got %b expected %b", ctl, CTL_LU); end
        step();
        clear_inputs();
        #1;
        checks++;
        if (stall_cycles !== 4'd1 || flush_events !== 4'd1)
            begin errors++; $display("FAIL b2b_counts: sc=%0d fe=%0d expected 1 1", stall_cycles, flush_events); end
    endtask

    task automatic test_saturation();
        do_reset();
        memReadE = 1; rdE = 3; rs2D = 3;
        for (int i = 0; i < 20; i++) step();
        memReadE = 0; pcsrcE = 1;
        for (int i = 0; i < 20; i++) step();
        clear_inputs();
        #1;
        checks++;
        if (stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_stall: got %0d expected 15", stall_cycles); end
        checks++;
        if (flush_events !== 4'd15) begin errors++; $display("FAIL sat_flush: got %0d expected 15", flush_events); end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_kills_lu();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
